// File: rtl/operand_issue.sv
// Operand issue stage: decodes a 16-bit instruction, reads or forwards register
// operands into num1/num2, and writes the ALU result back one cycle later.
module operand_issue #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    input  logic              stall,
    output logic [DATA_W-1:0] num1,
    output logic [DATA_W-1:0] num2,
    output logic              alu_valid,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              zeroflag,
    output logic              nz_flag,
    input  logic [1:0]        rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic [15:0]       issue_cnt
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_LDI  = 2'b10;

    logic [DATA_W-1:0] regs [4];
    logic [1:0]        rd_p1;

    logic [1:0]        op, rd, rs, rt;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] src_a, src_b, op_a, op_b;
    logic              op_live;
    logic              accept, wb;

    assign op  = instr[15:14];
    assign rd  = instr[13:12];
    assign rs  = instr[11:10];
    assign rt  = instr[9:8];
    assign imm = DATA_W'(instr[7:0]);

    assign instr_ready = ~stall;
    assign accept      = instr_valid & ~stall;
    assign wb          = alu_valid & ~stall;
    assign rd_data     = regs[rd_sel];

    // The result being written back this edge is not yet in regs, so take it
    // straight from the ALU when the new instruction depends on it.
    always_comb begin
        src_a   = (alu_valid && rs == rd_p1) ? alu_res : regs[rs];
        src_b   = (alu_valid && rt == rd_p1) ? alu_res : regs[rt];
        op_a    = '0;
        op_b    = '0;
        op_live = 1'b1;
        case (op)
            OP_ADD:  begin op_a = src_a; op_b = src_b; end
            OP_ADDI: begin op_a = src_a; op_b = imm;   end
            OP_LDI:  begin op_a = '0;    op_b = imm;   end
            default: op_live = 1'b0;
        endcase
    end

    // Stage p0 -> p1: operand registers; p1 -> writeback: register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            num1      <= '0;
            num2      <= '0;
            alu_valid <= 1'b0;
            rd_p1     <= '0;
            nz_flag   <= 1'b0;
            issue_cnt <= '0;
        end else begin
            if (wb) begin
                regs[rd_p1] <= alu_res;
                nz_flag     <= zeroflag;
                issue_cnt   <= issue_cnt + 16'd1;
            end
            if (accept) begin
                num1      <= op_a;
                num2      <= op_b;
                alu_valid <= op_live;
                rd_p1     <= rd;
            end else if (!stall) begin
                alu_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue with a behavioural adder standing in for the ALU.
module tb_operand_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        stall;
    logic [7:0]  num1, num2;
    logic        alu_valid;
    logic [7:0]  alu_res;
    logic        zeroflag;
    logic        nz_flag;
    logic [1:0]  rd_sel;
    logic [7:0]  rd_data;
    logic [15:0] issue_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign alu_res  = num1 + num2;
    assign zeroflag = (alu_res != 8'd0);

    operand_issue dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .stall(stall), .num1(num1), .num2(num2), .alu_valid(alu_valid),
        .alu_res(alu_res), .zeroflag(zeroflag), .nz_flag(nz_flag), .rd_sel(rd_sel),
        .rd_data(rd_data), .issue_cnt(issue_cnt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [1:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [1:0] rt,
                                        input logic [7:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] ins);
        instr_valid = 1'b1;
        instr       = ins;
    endtask

    task automatic idle();
        instr_valid = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        rd_sel = idx;
        #1;
        check(tag, {8'd0, rd_data}, {8'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0; stall = 1'b0; rd_sel = 2'd0;
        #12;
        check("rst_alu_valid", {15'd0, alu_valid}, 16'd0);
        check("rst_num1", {8'd0, num1}, 16'd0);
        check("rst_cnt", issue_cnt, 16'd0);
        check_reg("rst_r3", 2'd3, 8'd0);
        rst_n = 1'b1;
        #1;
        check("ready_idle", {15'd0, instr_ready}, 16'd1);

        // LDI R1,#5 ; ADDI R2,R1,#3
        offer(enc(2'b10, 2'd1, 2'd0, 2'd0, 8'd5));
        tick();
        check("ldi_valid", {15'd0, alu_valid}, 16'd1);
        check("ldi_num2", {8'd0, num2}, 16'd5);
        offer(enc(2'b01, 2'd2, 2'd1, 2'd0, 8'd3));
        tick();
        check("fwd_num1", {8'd0, num1}, 16'd5);
        check("addi_num2", {8'd0, num2}, 16'd3);
        check_reg("r1_eq5", 2'd1, 8'd5);
        idle();
        tick();
        check_reg("r2_eq8", 2'd2, 8'd8);
        check("nz_set", {15'd0, nz_flag}, 16'd1);
        check("cnt_2", issue_cnt, 16'd2);
        check("valid_drop", {15'd0, alu_valid}, 16'd0);

        // LDI R0,#200 ; LDI R3,#56 ; ADD R1,R0,R3 -> wraps to 0
        offer(enc(2'b10, 2'd0, 2'd0, 2'd0, 8'd200)); tick();
        offer(enc(2'b10, 2'd3, 2'd0, 2'd0, 8'd56));  tick();
        offer(enc(2'b00, 2'd1, 2'd0, 2'd3, 8'd0));   tick();
        check("add_num1", {8'd0, num1}, 16'd200);
        check("add_fwd_num2", {8'd0, num2}, 16'd56);
        idle(); tick();
        check_reg("r1_wrap", 2'd1, 8'd0);
        check("nz_clear", {15'd0, nz_flag}, 16'd0);
        check("cnt_5", issue_cnt, 16'd5);

        // LDI R2,#7 ; ADD R2,R2,R2 (both operands forwarded)
        offer(enc(2'b10, 2'd2, 2'd0, 2'd0, 8'd7)); tick();
        offer(enc(2'b00, 2'd2, 2'd2, 2'd2, 8'd0)); tick();
        check("dbl_num1", {8'd0, num1}, 16'd7);
        check("dbl_num2", {8'd0, num2}, 16'd7);
        idle(); tick();
        check_reg("r2_eq14", 2'd2, 8'd14);
        check("cnt_7", issue_cnt, 16'd7);

        // ADDI R3,R3,#4 then stall 3 cycles while another instruction is offered
        offer(enc(2'b01, 2'd3, 2'd3, 2'd0, 8'd4)); tick();
        offer(enc(2'b10, 2'd0, 2'd0, 2'd0, 8'd9));
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ready", {15'd0, instr_ready}, 16'd0);
            check("stall_num1", {8'd0, num1}, 16'd56);
            check("stall_num2", {8'd0, num2}, 16'd4);
            check("stall_valid", {15'd0, alu_valid}, 16'd1);
            check("stall_cnt", issue_cnt, 16'd7);
            check_reg("stall_r3", 2'd3, 8'd56);
        end
        stall = 1'b0;
        idle(); tick();
        check_reg("r3_eq60", 2'd3, 8'd60);
        check_reg("r0_not_ldi", 2'd0, 8'd200);
        check("cnt_8", issue_cnt, 16'd8);

        // LDI R0,#1 ; NOP ; LDI R1,#2
        offer(enc(2'b10, 2'd0, 2'd0, 2'd0, 8'd1)); tick();
        offer(enc(2'b11, 2'd3, 2'd0, 2'd0, 8'd99)); tick();
        check("nop_valid", {15'd0, alu_valid}, 16'd0);
        check_reg("r0_eq1", 2'd0, 8'd1);
        offer(enc(2'b10, 2'd1, 2'd0, 2'd0, 8'd2)); tick();
        check("ldi2_valid", {15'd0, alu_valid}, 16'd1);
        check("ldi2_num2", {8'd0, num2}, 16'd2);
        instr_valid = 1'b0;
        instr = enc(2'b10, 2'd3, 2'd0, 2'd0, 8'hFF);
        tick();
        check_reg("r1_eq2", 2'd1, 8'd2);
        check("cnt_10", issue_cnt, 16'd10);
        tick();
        check_reg("r3_ignored", 2'd3, 8'd60);
        check("cnt_still10", issue_cnt, 16'd10);

        // ADDI R1,R0,#5 in flight, then asynchronous reset mid-cycle
        offer(enc(2'b01, 2'd1, 2'd0, 2'd0, 8'd5)); tick();
        check("pre_rst_valid", {15'd0, alu_valid}, 16'd1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", {15'd0, alu_valid}, 16'd0);
        check("async_num2", {8'd0, num2}, 16'd0);
        check("async_cnt", issue_cnt, 16'd0);
        check_reg("async_r1", 2'd1, 8'd0);
        tick();
        #2;
        rst_n = 1'b1;
        check_reg("post_rst_r1", 2'd1, 8'd0);
        offer(enc(2'b10, 2'd1, 2'd0, 2'd0, 8'd3)); tick();
        check("first_edge_valid", {15'd0, alu_valid}, 16'd1);
        check("first_edge_num2", {8'd0, num2}, 16'd3);
        idle(); tick();
        check_reg("first_wb_r1", 2'd1, 8'd3);
        check("first_wb_cnt", issue_cnt, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction offered this cycle
- instr_ready  out  1  issue stage can accept; equals ~stall
- instr  in  16  [15:14] op, [13:12] rd, [11:10] rs, [9:8] rt, [7:0] imm
- stall  in  1  freeze request from downstream
- num1  out  8  registered ALU operand A
- num2  out  8  registered ALU operand B
- alu_valid  out  1  num1/num2 carry a live instruction this cycle
- alu_res  in  8  combinational ALU sum of num1+num2, same cycle
- zeroflag  in  1  ALU flag; 1 = alu_res nonzero, 0 = alu_res zero
- nz_flag  out  1  registered zeroflag of last written-back instruction
- rd_sel  in  2  debug register select
- rd_data  out  8  combinational R[rd_sel]
- issue_cnt  out  16  count of instructions written back

Function
REQ-002 SHALL hold four 8-bit registers R0..R3, all writable.
REQ-003 SHALL accept an instruction on a rising edge when instr_valid=1 and instr_ready=1 (handshake).
REQ-004 SHALL decode op: 00 ADD (num1=R[rs], num2=R[rt]); 01 ADDI (num1=R[rs], num2=imm); 10 LDI (num1=0, num2=imm); 11 NOP (accepted, discarded, alu_valid not asserted).
REQ-005 SHALL register operands at the accept edge; num1/num2/alu_valid valid in the following cycle (latency 1 accept-to-operands).
REQ-006 SHALL write alu_res into R[rd] and zeroflag into nz_flag at the edge ending a cycle with alu_valid=1 and stall=0 (latency 2 accept-to-writeback).
REQ-007 SHALL increment issue_cnt by 1 per writeback; wraps 16'hFFFF -> 0.
REQ-008 SHALL forward alu_res instead of R[x] when an accepted instruction's rs or rt equals the rd of the instruction currently at alu_valid=1; no bubble for back-to-back dependencies.
REQ-009 SHALL forward for both operands when rs=rt=in-flight rd.
REQ-010 SHALL hold num1, num2, alu_valid, all R, nz_flag, issue_cnt unchanged while stall=1; no accept, no writeback.
REQ-011 SHALL deassert alu_valid the cycle after a writeback when no instruction was accepted on that edge.
REQ-012 SHALL support full throughput: accept and writeback on the same edge; writeback to R[rd] completes before the next operands are read except via REQ-008 forwarding.
REQ-013 SHALL compute 8-bit sums modulo 256; no carry output.
REQ-014 SHALL return rd_data from the register array (post-writeback value), never forwarded.
REQ-015 SHALL ignore instr contents when instr_valid=0.

Reset
REQ-016 SHALL, on rst_n=0 (asynchronous, regardless of clk): R0..R3=0, num1=0, num2=0, alu_valid=0, nz_flag=0, issue_cnt=0.
REQ-017 SHALL discard an in-flight instruction on reset; no writeback occurs for it.
REQ-018 SHALL accept an instruction on the first rising edge after rst_n deasserts.

Verification
REQ-019 LDI R1,#5 then ADDI R2,R1,#3 back-to-back -> num1=5 forwarded, R2=8, nz_flag=1, issue_cnt=2.
REQ-020 LDI R0,#200; LDI R3,#56; ADD R1,R0,R3 -> R1=0 (wrap), nz_flag=0.
REQ-021 ADD R2,R2,R2 with R2 in flight = 7 -> num1=num2=7, R2=14.
REQ-022 Assert stall for 3 cycles with ADDI in flight -> operands held, no writeback, instr_ready=0; completes 1 edge after stall drops.
REQ-023 NOP between two LDIs -> alu_valid=0 for one cycle, issue_cnt=2.
REQ-024 rst_n low mid-cycle with ADDI at alu_valid=1 -> outputs zero immediately, target register stays 0.
